spi_sample_rx: RTL and testbench
================================

SPI_SAMPLE_RX -- requirements
Module: spi_sample_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronizers on MCU_SCK, MCU_SS, MCU_MOSI.
REQ-002 Parameter FIFO_DEPTH, default 4: output sample FIFO depth in 4-bit entries; power of two, minimum 2.
REQ-003 MCU_CLK_25_000  in  1  sole clock; all state on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 MCU_SCK  in  1  SPI clock from the bridge; asynchronous to MCU_CLK_25_000.
REQ-006 MCU_SS  in  1  SPI select, active low; asynchronous.
REQ-007 MCU_MOSI  in  1  SPI data, MSB first; asynchronous.
REQ-008 SAMPLE  out  4  {I1,I0,Q1,Q0} at FIFO head.
REQ-009 SAMPLE_VALID  out  1  FIFO non-empty.
REQ-010 SAMPLE_READY  in  1  consumer accepts SAMPLE when SAMPLE_VALID and SAMPLE_READY are both high.
REQ-011 CHECK_EN  in  1  enables the self-test counter-pattern checker.
REQ-012 FRAME_ERR  out  1  one-cycle pulse: MCU_SS deasserted with a partial byte.
REQ-013 OVERFLOW  out  1  sticky: sample dropped because the FIFO was full.
REQ-014 MISMATCH_CNT  out  8  saturating count of self-test byte mismatches.

Function
REQ-015 SPI mode 0: MOSI captured on a synchronized MCU_SCK rising edge while synchronized MCU_SS is low; bridge changes MOSI on falling edges.
REQ-016 SCK high and low phases each last at least 2 MCU_CLK_25_000 periods; slower SCK needs no other constraint.
REQ-017 Edge detection uses the last synchronizer stage plus one history flop; a bit enters the shifter SYNC_STAGES+1 cycles after the MCU_SCK rise.
REQ-018 A 3-bit bit counter counts captured bits; on the 8th bit, the byte is latched into a holding register and the counter wraps to 0.
REQ-019 Byte packing: bits[7:4] form sample n, bits[3:0] form sample n+1; the upper nibble is pushed into the FIFO one cycle after the byte latches, the lower nibble two cycles after.
REQ-020 The FIFO is first-word fall-through: SAMPLE is valid in the cycle SAMPLE_VALID rises, and SAMPLE/SAMPLE_VALID are driven from registers.
REQ-021 A push and a pop in the same cycle on a full FIFO are both accepted, with no overflow.
REQ-022 A push to a full FIFO with no pop drops the nibble, sets OVERFLOW, and leaves FIFO contents and pointers unchanged.
REQ-023 Pointers wrap modulo FIFO_DEPTH; the full/empty distinction uses an extra pointer bit or an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-024 A synchronized MCU_SS rise with bit counter ≠ 0: discard the partial byte, clear the counter, pulse FRAME_ERR for 1 cycle, push nothing.
REQ-025 A synchronized MCU_SS rise with bit counter = 0: no error; already-latched bytes still complete both pushes.
REQ-026 SCK edges while MCU_SS is high are ignored.
REQ-027 Checker: with CHECK_EN high, the first byte after CHECK_EN rises or after an MCU_SS fall seeds the expected value; each later byte is compared with previous+1 mod 256.
REQ-028 A checker mismatch increments MISMATCH_CNT, saturating at 255; the received byte re-seeds the expectation.
REQ-029 With CHECK_EN low, the checker is idle and MISMATCH_CNT holds its value; samples flow regardless of CHECK_EN.

Reset
REQ-030 RESET high at a clock edge clears synchronizers, shifter, bit counter, holding register, push sequencer, FIFO pointers and checker seed flag.
REQ-031 Output reset values: SAMPLE=0, SAMPLE_VALID=0, FRAME_ERR=0, OVERFLOW=0, MISMATCH_CNT=0.
REQ-032 Reset asserted mid-byte or mid-push abandons that byte, with no FRAME_ERR.
REQ-033 After RESET falls, the first captured bit is bit 7 of a new byte, even if MCU_SS is already low.

Verification
REQ-034 SS low, SCK = clk/6, bytes 0xA5, 0x3C, SAMPLE_READY=1 -> SAMPLE sequence 0xA, 0x5, 0x3, 0xC; FRAME_ERR=0.
REQ-035 SAMPLE_READY=0, FIFO_DEPTH=4, 3 bytes sent -> 4 samples held, OVERFLOW=1 at the 5th push; after draining, SAMPLE values are the first 4 nibbles.
REQ-036 SS rises after 5 bits of 0xFF, then byte 0x12 is sent -> one FRAME_ERR pulse; only samples 0x1, 0x2 appear.
REQ-037 CHECK_EN=1, bytes 0x00..0x09 with 0x05 replaced by 0x55 -> MISMATCH_CNT=2 (0x55 and 0x06); 300 bad bytes -> MISMATCH_CNT=255.
REQ-038 RESET pulsed for 1 cycle after 4 bits of 0xF0, then 0x81 is sent -> outputs at reset values; next samples are 0x8, 0x1.

Source files
------------

// File: rtl/spi_sample_rx.sv
// spi_sample_rx: receives 8-bit SPI (mode 0) bytes from an asynchronous bridge,
// splits each byte into two 4-bit I/Q samples and queues them in a small
// first-word-fall-through FIFO. It also has an optional counter-pattern
// self-test checker.
//
// Push sequencer states
//   state       | meaning
//   ST_IDLE     | waiting for a latched byte; upper nibble pushed on its strobe
//   ST_PUSH_LO  | lower nibble of the latched byte is pushed this cycle
module spi_sample_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       MCU_CLK_25_000,
  input  logic       RESET,
  input  logic       MCU_SCK,
  input  logic       MCU_SS,
  input  logic       MCU_MOSI,
  output logic [3:0] SAMPLE,
  output logic       SAMPLE_VALID,
  input  logic       SAMPLE_READY,
  input  logic       CHECK_EN,
  output logic       FRAME_ERR,
  output logic       OVERFLOW,
  output logic [7:0] MISMATCH_CNT
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_PUSH_LO
  } push_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_hist;
  logic                   ss_hist;

  logic sck_s;
  logic ss_s;
  logic mosi_s;
  logic sck_rise;
  logic ss_rise;
  logic ss_fall;
  logic capture;

  // Shift the raw SPI pins through the synchronizer chains.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync[0]  <= MCU_SCK;
      ss_sync[0]   <= MCU_SS;
      mosi_sync[0] <= MCU_MOSI;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i]  <= sck_sync[i-1];
        ss_sync[i]   <= ss_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
    end
  end

  // Keep one cycle of history on SCK and SS for edge detection.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      sck_hist <= 1'b0;
      ss_hist  <= 1'b0;
    end else begin
      sck_hist <= sck_s;
      ss_hist  <= ss_s;
    end
  end

  // Decode SCK/SS edges from the last synchronizer stage and its history flop.
  always_comb begin
    sck_s    = sck_sync[SYNC_STAGES-1];
    ss_s     = ss_sync[SYNC_STAGES-1];
    mosi_s   = mosi_sync[SYNC_STAGES-1];
    sck_rise = sck_s & ~sck_hist;
    ss_rise  = ss_s & ~ss_hist;
    ss_fall  = ~ss_s & ss_hist;
    // MOSI passes through the same chain depth as SCK, so it is aligned with
    // the detected rise; the bridge only changes it on SCK falling edges.
    capture  = sck_rise & ~ss_s;
  end

  // ---------------------------------------------------------------------------
  // Bit shifter, bit counter, holding register, frame error
  // ---------------------------------------------------------------------------
  logic [6:0] shift_reg;
  logic [2:0] bit_cnt;
  logic [7:0] hold_reg;
  logic       byte_stb;

  // Assemble bits MSB first; on the eighth bit latch the byte and strobe it.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      hold_reg  <= '0;
      byte_stb  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (ss_rise) begin
        // Deselect in the middle of a byte throws the partial byte away.
        if (bit_cnt != 3'd0) begin
          FRAME_ERR <= 1'b1;
        end
        bit_cnt <= '0;
      end else if (capture) begin
        shift_reg <= {shift_reg[5:0], mosi_s};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          hold_reg <= {shift_reg, mosi_s};
          byte_stb <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Push sequencer: upper nibble one cycle after latch, lower nibble after two
  // ---------------------------------------------------------------------------
  push_state_t state;
  push_state_t state_next;
  logic        push;
  logic [3:0]  push_data;

  // Register the push sequencer state.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Choose the next state and which nibble, if any, is pushed this cycle.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    push_data  = 4'd0;
    case (state)
      ST_IDLE: begin
        if (byte_stb) begin
          push       = 1'b1;
          push_data  = hold_reg[7:4];
          state_next = ST_PUSH_LO;
        end
      end
      ST_PUSH_LO: begin
        push       = 1'b1;
        push_data  = hold_reg[3:0];
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO (first-word fall-through, registered head and valid)
  // ---------------------------------------------------------------------------
  logic [3:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_next;
  logic [AW:0] rd_next;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        drop;

  // Work out the handshake and the pointer values for the next cycle.
  always_comb begin
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop     = SAMPLE_VALID & SAMPLE_READY;
    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    push_ok = push & (~full | pop);
    drop    = push & full & ~pop;
    wr_next = wr_ptr + (AW+1)'(push_ok);
    rd_next = rd_ptr + (AW+1)'(pop);
  end

  // Write accepted nibbles into the storage array.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Advance the pointers and preload the head register for the next cycle.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      SAMPLE       <= 4'd0;
      SAMPLE_VALID <= 1'b0;
      OVERFLOW     <= 1'b0;
    end else begin
      wr_ptr       <= wr_next;
      rd_ptr       <= rd_next;
      SAMPLE_VALID <= (wr_next != rd_next);
      if (wr_next != rd_next) begin
        // The new head may be the nibble being written this very cycle.
        if (push_ok && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
          SAMPLE <= push_data;
        end else begin
          SAMPLE <= mem[rd_next[AW-1:0]];
        end
      end
      if (drop) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counter-pattern self-test checker
  // ---------------------------------------------------------------------------
  logic       seeded;
  logic [7:0] expect_byte;

  // Compare each byte with previous+1; any byte re-seeds the expectation.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      seeded       <= 1'b0;
      expect_byte  <= 8'd0;
      MISMATCH_CNT <= 8'd0;
    end else if (!CHECK_EN || ss_fall) begin
      seeded <= 1'b0;
    end else if (byte_stb) begin
      seeded      <= 1'b1;
      expect_byte <= hold_reg + 8'd1;
      if (seeded && (hold_reg != expect_byte) && (MISMATCH_CNT != 8'hFF)) begin
        MISMATCH_CNT <= MISMATCH_CNT + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_sample_rx.sv
// Directed bench for spi_sample_rx: a table of two-byte frames plus hand
// sequences for frame error, checker, overflow and mid-byte reset.
module tb_spi_sample_rx;

  logic       clk;
  logic       rst;
  logic       sck;
  logic       ss;
  logic       mosi;
  logic [3:0] sample;
  logic       sample_valid;
  logic       sample_ready;
  logic       check_en;
  logic       frame_err;
  logic       overflow;
  logic [7:0] mismatch_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fe_cnt    = 0;
  int fe0;
  logic [3:0] got_q[$];

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] nib;   // expected nibbles, first sample in bits [15:12]
  } vec_t;

  vec_t vecs[4];

  spi_sample_rx dut (
    .MCU_CLK_25_000 (clk),
    .RESET          (rst),
    .MCU_SCK        (sck),
    .MCU_SS         (ss),
    .MCU_MOSI       (mosi),
    .SAMPLE         (sample),
    .SAMPLE_VALID   (sample_valid),
    .SAMPLE_READY   (sample_ready),
    .CHECK_EN       (check_en),
    .FRAME_ERR      (frame_err),
    .OVERFLOW       (overflow),
    .MISMATCH_CNT   (mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record handshaken samples and FRAME_ERR pulses away from the active edge.
  always @(negedge clk) begin
    if (sample_valid && sample_ready) got_q.push_back(sample);
    if (frame_err) fe_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // SCK = clk/6: three cycles low with data set up, three cycles high.
  task automatic send_bit(input logic b);
    mosi = b;
    tick(3);
    sck = 1'b1;
    tick(3);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  function automatic int q_at(input int idx);
    if (idx < got_q.size()) return int'(got_q[idx]);
    return -1;
  endfunction

  initial begin
    vecs[0] = '{b0: 8'hA5, b1: 8'h3C, nib: 16'hA53C};
    vecs[1] = '{b0: 8'h00, b1: 8'hFF, nib: 16'h00FF};
    vecs[2] = '{b0: 8'h12, b1: 8'h34, nib: 16'h1234};
    vecs[3] = '{b0: 8'hF0, b1: 8'h0F, nib: 16'hF00F};

    sck = 1'b0; ss = 1'b1; mosi = 1'b0;
    sample_ready = 1'b1; check_en = 1'b0; rst = 1'b1;
    tick(3);
    chk("rst_sample",   int'(sample), 0);
    chk("rst_valid",    int'(sample_valid), 0);
    chk("rst_frame",    int'(frame_err), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_mismatch", int'(mismatch_cnt), 0);
    rst = 1'b0;
    tick(4);
    ss = 1'b0;
    tick(6);

    // Table-driven two-byte frames with READY held high.
    for (int v = 0; v < 4; v++) begin
      got_q.delete();
      fe0 = fe_cnt;
      send_byte(vecs[v].b0);
      send_byte(vecs[v].b1);
      tick(12);
      chk($sformatf("v%0d_count", v), got_q.size(), 4);
      for (int j = 0; j < 4; j++) begin
        logic [15:0] n;
        n = vecs[v].nib;
        chk($sformatf("v%0d_nib%0d", v, j), q_at(j), int'(n[15-4*j -: 4]));
      end
      chk($sformatf("v%0d_frame_err", v), fe_cnt - fe0, 0);
    end

    // Partial byte, SCK activity while deselected, then a clean byte.
    got_q.delete();
    fe0 = fe_cnt;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    ss = 1'b1;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      sck = 1'b1; tick(3);
      sck = 1'b0; tick(3);
    end
    ss = 1'b0;
    tick(6);
    send_byte(8'h12);
    tick(12);
    chk("fe_pulses", fe_cnt - fe0, 1);
    chk("fe_count", got_q.size(), 2);
    chk("fe_nib0", q_at(0), 1);
    chk("fe_nib1", q_at(1), 2);

    // Counter-pattern checker.
    check_en = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) send_byte((i == 5) ? 8'h55 : 8'(i));
    tick(12);
    chk("chk_mismatch2", int'(mismatch_cnt), 2);
    for (int i = 0; i < 300; i++) send_byte(8'h00);
    tick(12);
    chk("chk_saturate", int'(mismatch_cnt), 255);
    check_en = 1'b0;
    send_byte(8'h77);
    tick(12);
    chk("chk_hold", int'(mismatch_cnt), 255);

    // Overflow with the consumer stalled.
    sample_ready = 1'b0;
    tick(4);
    got_q.delete();
    send_byte(8'h12);
    send_byte(8'h34);
    tick(12);
    chk("ovf_before", int'(overflow), 0);
    chk("ovf_valid", int'(sample_valid), 1);
    chk("ovf_head", int'(sample), 1);
    send_byte(8'h56);
    tick(12);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_head_kept", int'(sample), 1);
    sample_ready = 1'b1;
    tick(12);
    chk("ovf_drain_count", got_q.size(), 4);
    for (int j = 0; j < 4; j++) chk($sformatf("ovf_nib%0d", j), q_at(j), j + 1);
    chk("ovf_empty", int'(sample_valid), 0);

    // Reset after four bits of 0xF0, then a fresh byte.
    got_q.delete();
    fe0 = fe_cnt;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mrst_sample",   int'(sample), 0);
    chk("mrst_valid",    int'(sample_valid), 0);
    chk("mrst_frame",    int'(frame_err), 0);
    chk("mrst_overflow", int'(overflow), 0);
    chk("mrst_mismatch", int'(mismatch_cnt), 0);
    tick(4);
    send_byte(8'h81);
    tick(12);
    chk("mrst_count", got_q.size(), 2);
    chk("mrst_nib0", q_at(0), 8);
    chk("mrst_nib1", q_at(1), 1);
    chk("mrst_fe", fe_cnt - fe0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
